// File: rtl/decode_issue_scheduler.sv
// ---------------------------------------------------------------------------
// decode_issue_scheduler
//
// In-order decode-to-issue buffer. Up to four decoded bundles arrive per
// cycle. Valid lanes are packed together in lane order and appended at the
// tail of a circular buffer. Up to two bundles leave per cycle from the head,
// strictly in program order, and each one waits for its functional unit's
// ready bit.
//
// Optional feature (macro SCHED_BYPASS_EN): when the buffer is empty and not
// stalled, the first two valid lanes may issue on the edge they arrive. They
// follow the same slot rules as buffered bundles. Lanes that do not issue are
// enqueued as usual.
//
// Handshake: on a posedge where stall_o is low, every lane whose enable_i bit
// is set is accepted. While stall_o is high, all lane inputs are ignored.
// An issue slot holds one bundle for exactly the cycle in which its
// issueValid_o bit is high. Downstream must accept it, because fuReady_i was
// sampled one cycle earlier.
//
// Ports:
//   clock_i, reset_i   clock, synchronous active-high reset
//   flush_i            drop all buffered bundles (reset has priority)
//   enable_i[3:0]      per-lane valid, bit 0 = lane 1 (oldest)
//   payload_i          4 bundles; lane 1 occupies the most significant slice
//   funcUnitType_i     4 FU codes; lane 1 occupies the most significant slice
//   fuReady_i          per FU type ready
//   stall_o            registered back-pressure to decode
//   issueValid_o[1:0]  bit 0 = older slot
//   issuePayload_o     slot 0 occupies the most significant slice
//   issueFu_o          slot 0 occupies the most significant slice
//   occupancy_o        current buffer entry count
// ---------------------------------------------------------------------------
module decode_issue_scheduler #(
  parameter int payloadWidth     = 160,
  parameter int funcUnitCodeSize = 3,
  parameter int numFuTypes       = 8,
  parameter int queueDepth       = 8
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            flush_i,
  input  logic [3:0]                      enable_i,
  input  logic [4*payloadWidth-1:0]       payload_i,
  input  logic [4*funcUnitCodeSize-1:0]   funcUnitType_i,
  input  logic [numFuTypes-1:0]           fuReady_i,
  output logic                            stall_o,
  output logic [1:0]                      issueValid_o,
  output logic [2*payloadWidth-1:0]       issuePayload_o,
  output logic [2*funcUnitCodeSize-1:0]   issueFu_o,
  output logic [$clog2(queueDepth):0]     occupancy_o
);

  localparam int PtrW = $clog2(queueDepth);
  localparam int CntW = PtrW + 1;

  typedef logic [payloadWidth-1:0]     pay_t;
  typedef logic [funcUnitCodeSize-1:0] fu_t;
  typedef logic [PtrW-1:0]             ptr_t;
  typedef logic [CntW-1:0]             cnt_t;

  // Buffer storage. The contents need no reset because the head, tail and
  // count registers fully describe which entries are live.
  pay_t pay_mem [queueDepth];
  fu_t  fu_mem  [queueDepth];

  ptr_t head, tail, head1;
  cnt_t count, count_next, avail, deq, n_enq;

  pay_t lane_pay [4];
  fu_t  lane_fu  [4];
  pay_t cmp_pay  [4];
  fu_t  cmp_fu   [4];
  logic [2:0] n_en;

  pay_t cand_pay [2];
  fu_t  cand_fu  [2];
  logic use_byp;
  logic fire0, fire1;
  logic [1:0] n_fire, n_byp;
  logic accept, stall_next;

  pay_t iss_pay [2];
  fu_t  iss_fu  [2];

  // Unpack the lane vectors. Lane 1 sits in the most significant slice.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_pay[i] = payload_i[(4-i)*payloadWidth-1 -: payloadWidth];
      lane_fu[i]  = funcUnitType_i[(4-i)*funcUnitCodeSize-1 -: funcUnitCodeSize];
    end
  end

  // Pack the valid lanes into slots 0..n_en-1 in lane order.
  always_comb begin
    n_en = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cmp_pay[i] = '0;
      cmp_fu[i]  = '0;
    end
    for (int i = 0; i < 4; i++) begin
      if (enable_i[i]) begin
        cmp_pay[n_en[1:0]] = lane_pay[i];
        cmp_fu[n_en[1:0]]  = lane_fu[i];
        n_en = n_en + 3'd1;
      end
    end
  end

  // Choose the issue candidates. The issue decision uses the buffer state
  // before this edge's enqueue. With bypass enabled and the buffer empty, the
  // arriving lanes take the place of the buffer head.
  always_comb begin
    head1       = head + ptr_t'(1);
    cand_pay[0] = pay_mem[head];
    cand_fu[0]  = fu_mem[head];
    cand_pay[1] = pay_mem[head1];
    cand_fu[1]  = fu_mem[head1];
    avail       = count;
    use_byp     = 1'b0;
`ifdef SCHED_BYPASS_EN
    if ((count == '0) && !stall_o) begin
      use_byp     = 1'b1;
      cand_pay[0] = cmp_pay[0];
      cand_fu[0]  = cmp_fu[0];
      cand_pay[1] = cmp_pay[1];
      cand_fu[1]  = cmp_fu[1];
      avail       = cnt_t'(n_en);
    end
`else
`endif
  end

  // Slot 1 can only follow slot 0. The two slots must target different FU
  // types, so one unit never gets two bundles on the same edge.
  always_comb begin
    fire0  = (avail != '0) && fuReady_i[cand_fu[0]];
    fire1  = fire0 && (avail >= cnt_t'(2)) && (cand_fu[1] != cand_fu[0]) &&
             fuReady_i[cand_fu[1]];
    n_fire = {1'b0, fire0} + {1'b0, fire1};
    deq    = use_byp ? '0 : cnt_t'(n_fire);
    n_byp  = use_byp ? n_fire : 2'd0;
    accept = !stall_o;
    n_enq  = accept ? (cnt_t'(n_en) - cnt_t'(n_byp)) : '0;
    count_next = count + n_enq - deq;
    // Stall whenever four more lanes might not fit.
    stall_next = count_next > cnt_t'(queueDepth - 4);
  end

  // Buffer writes. Packed lanes that were bypassed are skipped, and the
  // remaining lanes land contiguously from the tail.
  always_ff @(posedge clock_i) begin
    if (!reset_i && !flush_i && accept) begin
      for (int j = 0; j < 4; j++) begin
        if ((3'(j) >= {1'b0, n_byp}) && (3'(j) < n_en)) begin
          pay_mem[tail + ptr_t'(j) - ptr_t'(n_byp)] <= cmp_pay[j];
          fu_mem[tail + ptr_t'(j) - ptr_t'(n_byp)]  <= cmp_fu[j];
        end
      end
    end
  end

  // Control and issue registers. Reset has priority over flush, and flush
  // has priority over enqueue and issue.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      stall_o      <= 1'b0;
      issueValid_o <= 2'b00;
      iss_pay[0]   <= '0;
      iss_pay[1]   <= '0;
      iss_fu[0]    <= '0;
      iss_fu[1]    <= '0;
    end else if (flush_i) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      stall_o      <= 1'b0;
      issueValid_o <= 2'b00;
    end else begin
      head         <= head + ptr_t'(deq);
      tail         <= tail + ptr_t'(n_enq);
      count        <= count_next;
      stall_o      <= stall_next;
      issueValid_o <= {fire1, fire0};
      // A slot that does not fire keeps its previous payload and FU code.
      if (fire0) begin
        iss_pay[0] <= cand_pay[0];
        iss_fu[0]  <= cand_fu[0];
      end
      if (fire1) begin
        iss_pay[1] <= cand_pay[1];
        iss_fu[1]  <= cand_fu[1];
      end
    end
  end

  assign issuePayload_o = {iss_pay[0], iss_pay[1]};
  assign issueFu_o      = {iss_fu[0], iss_fu[1]};
  assign occupancy_o    = count;

endmodule
